// File: rtl/bus_arbiter_rr_pkg.sv
// Shared main-bus constants: master count, default timeout and master index map.
package Skeleton_package;

    localparam int unsigned NUM_MASTERS     = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 12;

    // Master index assignments on the main bus.
    localparam int unsigned MASTER_USB      = 0;

    // Width needed to index n items (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after last_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    // Walk N candidates starting at last_ptr+1; the first active request wins.
    always_comb begin
        logic [IDX_W:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = {1'b0, last_ptr} + (IDX_W + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                     = 1'b1;
                idx                     = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin main-bus arbiter and transaction sequencer (grant, decode wait, strobe or timeout abort).
module bus_arbiter_rr
    import Skeleton_package::*;
#(
    parameter int unsigned DEVICE_MAX_NUMBER = NUM_MASTERS,
    parameter int unsigned CLK_MAX_TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int unsigned IDX_W             = $clog2(DEVICE_MAX_NUMBER)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEVICE_MAX_NUMBER-1:0] barq_i,
    output logic [DEVICE_MAX_NUMBER-1:0] bagd_o,
    output logic                         target_ready_o,
    input  logic                         address_valid_i,
    output logic                         data_strobe_o,
    output logic                         error_o,
    output logic [IDX_W-1:0]             err_master_o,
    output logic                         busy_o
);

    localparam int unsigned    CNT_W    = $clog2(CLK_MAX_TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(CLK_MAX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_STROBE,
        S_RELEASE
    } state_t;

    state_t                         state, state_nx;
    logic [IDX_W-1:0]               last_ptr, last_ptr_nx;
    logic [IDX_W-1:0]               grant_idx, grant_idx_nx;
    logic [CNT_W-1:0]               cnt, cnt_nx;
    logic [DEVICE_MAX_NUMBER-1:0]   bagd_nx;
    logic                           tready_nx;
    logic                           strobe_nx;
    logic                           error_nx;
    logic [IDX_W-1:0]               err_master_nx;

    logic [DEVICE_MAX_NUMBER-1:0]   pick_grant;
    logic [IDX_W-1:0]               pick_idx;
    logic                           pick_any;

    rr_pick #(
        .N     (DEVICE_MAX_NUMBER),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (barq_i),
        .last_ptr (last_ptr),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // Next state and next output values; outputs are registered from these.
    always_comb begin
        state_nx      = state;
        last_ptr_nx   = last_ptr;
        grant_idx_nx  = grant_idx;
        cnt_nx        = cnt;
        bagd_nx       = '0;
        tready_nx     = 1'b0;
        strobe_nx     = 1'b0;
        error_nx      = 1'b0;
        err_master_nx = err_master_o;

        unique case (state)
            S_IDLE: begin
                if (pick_any) begin
                    state_nx     = S_GRANT;
                    bagd_nx      = pick_grant;
                    tready_nx    = 1'b1;
                    last_ptr_nx  = pick_idx;
                    grant_idx_nx = pick_idx;
                    cnt_nx       = '0;
                end
            end

            S_GRANT: begin
                bagd_nx   = bagd_o;
                tready_nx = 1'b1;
                cnt_nx    = (cnt == TMO_LAST) ? cnt : cnt + 1'b1;
                // A decoded address wins over both a dropped request and the timeout.
                if (address_valid_i) begin
                    state_nx  = S_STROBE;
                    strobe_nx = 1'b1;
                end else if (!barq_i[grant_idx]) begin
                    state_nx  = S_RELEASE;
                    bagd_nx   = '0;
                    tready_nx = 1'b0;
                end else if (cnt == TMO_LAST) begin
                    state_nx      = S_RELEASE;
                    bagd_nx       = '0;
                    tready_nx     = 1'b0;
                    error_nx      = 1'b1;
                    err_master_nx = grant_idx;
                end
            end

            S_STROBE: begin
                state_nx = S_RELEASE;
            end

            S_RELEASE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            last_ptr       <= IDX_W'(DEVICE_MAX_NUMBER - 1);
            grant_idx      <= '0;
            cnt            <= '0;
            bagd_o         <= '0;
            target_ready_o <= 1'b0;
            data_strobe_o  <= 1'b0;
            error_o        <= 1'b0;
            err_master_o   <= '0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_nx;
            last_ptr       <= last_ptr_nx;
            grant_idx      <= grant_idx_nx;
            cnt            <= cnt_nx;
            bagd_o         <= bagd_nx;
            target_ready_o <= tready_nx;
            data_strobe_o  <= strobe_nx;
            error_o        <= error_nx;
            err_master_o   <= err_master_nx;
            busy_o         <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: expected grants/outcomes queued at stimulus, checked by a monitor.
module tb_bus_arbiter_rr;

    localparam int N = 4;
    localparam int T = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] barq;
    logic [N-1:0] bagd;
    logic         tready;
    logic         av;
    logic         strobe;
    logic         error;
    logic [1:0]   err_master;
    logic         busy;

    bus_arbiter_rr #(
        .DEVICE_MAX_NUMBER (N),
        .CLK_MAX_TIMEOUT   (T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .barq_i          (barq),
        .bagd_o          (bagd),
        .target_ready_o  (tready),
        .address_valid_i (av),
        .data_strobe_o   (strobe),
        .error_o         (error),
        .err_master_o    (err_master),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int strobes;
        int err;
        int m;
    } outcome_t;

    logic [N-1:0] exp_grant[$];
    outcome_t     exp_out[$];

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, n_grants = 0, n_strobes = 0, n_errors = 0;
    int grant_cyc = 0, strobe_cyc = 0, error_cyc = 0, strobes_in_txn = 0;
    logic [N-1:0] prev_bagd = '0;
    int lat_tab[N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nsample();
        @(negedge clk);
        #1;
    endtask

    // kind: 0 grants, 1 strobes, 2 errors
    task automatic wait_evt(input int kind, input int target, input int budget, input string tag);
        int i = 0;
        int c;
        c = (kind == 0) ? n_grants : (kind == 1) ? n_strobes : n_errors;
        while (c < target && i < budget) begin
            nsample();
            i++;
            c = (kind == 0) ? n_grants : (kind == 1) ? n_strobes : n_errors;
        end
        check_eq(tag, 32'(c >= target), 32'd1);
    endtask

    task automatic push_txn(input logic [N-1:0] g, input int s, input int e, input int m);
        outcome_t o;
        o.strobes = s;
        o.err     = e;
        o.m       = m;
        exp_grant.push_back(g);
        exp_out.push_back(o);
    endtask

    // Address decoder stand-in: address_valid follows the granted master's latency (0 = never).
    initial begin
        av = 1'b0;
        forever begin
            int gcyc;
            int lat;
            @(posedge clk);
            #1;
            if (bagd != '0 && !strobe) begin
                gcyc++;
                lat = 0;
                for (int i = 0; i < N; i++) if (bagd[i]) lat = lat_tab[i];
                av = (lat != 0 && gcyc >= lat);
            end else begin
                gcyc = 0;
                av   = 1'b0;
            end
        end
    end

    // Monitor: checks each new grant and each completed transaction against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (bagd != '0 && prev_bagd == '0) begin
            n_grants++;
            grant_cyc      = cyc;
            strobes_in_txn = 0;
            if (exp_grant.size() == 0) begin
                check_eq("grant_unexpected", 32'(bagd), 32'd0);
            end else begin
                check_eq("grant", 32'(bagd), 32'(exp_grant.pop_front()));
            end
            check_eq("grant_onehot", 32'($onehot(bagd)), 32'd1);
            check_eq("grant_tready", 32'(tready), 32'd1);
        end else if (bagd != '0) begin
            check_eq("grant_hold", 32'(bagd), 32'(prev_bagd));
        end
        if (strobe) begin
            n_strobes++;
            strobe_cyc = cyc;
            strobes_in_txn++;
        end
        if (error) begin
            n_errors++;
            error_cyc = cyc;
        end
        if (bagd == '0 && prev_bagd != '0) begin
            check_eq("release_tready", 32'(tready), 32'd0);
            if (exp_out.size() == 0) begin
                check_eq("txn_unexpected", 32'd1, 32'd0);
            end else begin
                outcome_t o;
                o = exp_out.pop_front();
                check_eq("txn_strobes", 32'(strobes_in_txn), 32'(o.strobes));
                check_eq("txn_error", 32'(error), 32'(o.err));
                if (o.err != 0) check_eq("txn_err_master", 32'(err_master), 32'(o.m));
            end
        end
        prev_bagd = bagd;
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bagd"}, 32'(bagd), 32'd0);
        check_eq({tag, "_tready"}, 32'(tready), 32'd0);
        check_eq({tag, "_strobe"}, 32'(strobe), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
        check_eq({tag, "_errm"}, 32'(err_master), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s, base_e;
        rst  = 1'b1;
        barq = '0;
        for (int i = 0; i < N; i++) lat_tab[i] = 2;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Single USB request, decode two cycles after grant.
        push_txn(4'b0001, 1, 0, 0);
        tick();
        barq = 4'b0001;
        nsample();
        check_eq("t1_no_early_grant", 32'(bagd), 32'd0);
        nsample();
        check_eq("t1_grant_latency", 32'(bagd), 32'b0001);
        check_eq("t1_busy", 32'(busy), 32'd1);
        wait_evt(1, 1, 20, "t1_strobe_wait");
        check_eq("t1_strobe_lat", 32'(strobe_cyc - grant_cyc), 32'd2);
        tick();
        barq = '0;
        nsample();
        check_eq("t1_release_bagd", 32'(bagd), 32'd0);
        check_eq("t1_release_strobe", 32'(strobe), 32'd0);
        check_eq("t1_release_busy", 32'(busy), 32'd1);
        nsample();
        check_eq("t1_idle_busy", 32'(busy), 32'd0);
        check_eq("t1_no_error", 32'(n_errors), 32'd0);

        // Fresh reset, then all four masters requesting continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_txn(4'b0001, 1, 0, 0);
        push_txn(4'b0010, 1, 0, 0);
        push_txn(4'b0100, 1, 0, 0);
        push_txn(4'b1000, 1, 0, 0);
        push_txn(4'b0001, 1, 0, 0);
        base_s = n_strobes;
        barq   = 4'b1111;
        wait_evt(1, base_s + 5, 200, "t2_strobe_wait");
        tick();
        barq = '0;
        repeat (3) nsample();
        check_eq("t2_idle", 32'(busy), 32'd0);

        // Master 2 with no decoded target: timeout abort.
        lat_tab[2] = 0;
        push_txn(4'b0100, 0, 1, 2);
        base_s = n_strobes;
        base_e = n_errors;
        barq   = 4'b0100;
        wait_evt(2, base_e + 1, 60, "t3_error_wait");
        check_eq("t3_error_lat", 32'(error_cyc - grant_cyc), 32'(T));
        check_eq("t3_err_master", 32'(err_master), 32'd2);
        check_eq("t3_no_strobe", 32'(n_strobes), 32'(base_s));
        tick();
        barq = '0;
        nsample();
        check_eq("t3_error_pulse", 32'(error), 32'd0);
        check_eq("t3_err_master_hold", 32'(err_master), 32'd2);
        check_eq("t3_bus_free", 32'(busy), 32'd0);

        // Address valid on the last allowed GRANT cycle beats the timeout.
        lat_tab[2] = T;
        push_txn(4'b0100, 1, 0, 2);
        base_e = n_errors;
        base_s = n_strobes;
        barq   = 4'b0100;
        wait_evt(1, base_s + 1, 60, "t4_strobe_wait");
        check_eq("t4_strobe_lat", 32'(strobe_cyc - grant_cyc), 32'(T));
        tick();
        barq = '0;
        repeat (3) nsample();
        check_eq("t4_no_error", 32'(n_errors), 32'(base_e));

        // Granted master withdraws its request in GRANT.
        lat_tab[3] = 0;
        push_txn(4'b1000, 0, 0, 0);
        base_e = n_errors;
        base_s = n_strobes;
        barq   = 4'b1000;
        wait_evt(0, n_grants + 1, 20, "t5_grant_wait");
        repeat (3) nsample();
        tick();
        barq = '0;
        repeat (4) nsample();
        check_eq("t5_no_error", 32'(n_errors), 32'(base_e));
        check_eq("t5_no_strobe", 32'(n_strobes), 32'(base_s));
        check_eq("t5_idle", 32'(busy), 32'd0);

        // Reset during STROBE, then master 0 must win a full request set.
        push_txn(4'b0010, 1, 0, 0);
        base_s = n_strobes;
        barq   = 4'b0010;
        wait_evt(1, base_s + 1, 20, "t6_strobe_wait");
        rst = 1'b1;
        tick();
        check_all_zero("t6_midreset");
        rst  = 1'b0;
        push_txn(4'b0001, 1, 0, 0);
        base_s = n_strobes;
        barq   = 4'b1111;
        wait_evt(1, base_s + 1, 20, "t6_strobe_after_reset");
        tick();
        barq = '0;
        repeat (4) nsample();

        check_eq("sb_grants_left", 32'(exp_grant.size()), 32'd0);
        check_eq("sb_outcomes_left", 32'(exp_out.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
